// File: rtl/dial_rotation_engine_if.sv
// Instruction stream into the dial engine.
// valid/ready: the producer holds direction/count stable while instruction_valid is high;
// one instruction transfers on each rising edge where instruction_valid && instruction_ready.
interface dial_rotation_engine_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   direction;
  logic [COUNT_WIDTH-1:0] count;
  logic                   instruction_valid;
  logic                   instruction_ready;

  modport master (
    output direction,
    output count,
    output instruction_valid,
    input  instruction_ready
  );

  modport slave (
    input  direction,
    input  count,
    input  instruction_valid,
    output instruction_ready
  );
endinterface

// File: rtl/dial_rotation_engine.sv
// Circular dial solver: buffers rotation instructions in a small FIFO and rotates the
// dial up to DIAL_SIZE steps per cycle, counting landings on 0 (passes) and final-0 instructions (hits).
module dial_rotation_engine #(
  parameter int DIAL_SIZE   = 100,
  parameter int START_POS   = 50,
  parameter int COUNT_WIDTH = 16,
  parameter int FIFO_DEPTH  = 4,
  localparam int POS_WIDTH  = $clog2(DIAL_SIZE)
) (
  input  logic                    clock,
  input  logic                    reset,
  dial_rotation_engine_if.slave   instr,
  output logic [POS_WIDTH-1:0]    dial_position,
  output logic [31:0]             hits,
  output logic [31:0]             passes,
  output logic [31:0]             instructions_done,
  output logic                    busy,
  output logic [1:0]              o_state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ROTATE = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam int AW  = POS_WIDTH + 1;
  localparam int XW  = (COUNT_WIDTH > AW) ? COUNT_WIDTH : AW;
  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] N_A = AW'(DIAL_SIZE);
  localparam logic [XW-1:0] N_X = XW'(DIAL_SIZE);

  state_t                 r_state, w_state_nxt;
  logic [POS_WIDTH-1:0]   r_pos, w_pos_nxt;
  logic                   r_dir, w_dir_nxt;
  logic [COUNT_WIDTH-1:0] r_remaining, w_rem_nxt;
  logic [31:0]            r_hits, w_hits_nxt;
  logic [31:0]            r_passes, w_passes_nxt;
  logic [31:0]            r_done, w_done_nxt;

  logic [COUNT_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [FAW:0]           r_wr_ptr, r_rd_ptr;
  logic                   w_empty, w_full, w_push, w_pop;
  logic [COUNT_WIDTH:0]   w_head;

  logic [XW-1:0]          w_rem_x;
  logic [AW-1:0]          w_chunk, w_pos_a, w_sum, w_new_pos_a;
  logic [COUNT_WIDTH-1:0] w_rem_sub;
  logic                   w_pass;

  // Extra pointer bit separates full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FAW] != r_rd_ptr[FAW]) &&
                   (r_wr_ptr[FAW-1:0] == r_rd_ptr[FAW-1:0]);
  assign w_push  = instr.instruction_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rd_ptr[FAW-1:0]];

  assign instr.instruction_ready = !w_full;
  assign busy              = !w_empty || (r_state != S_IDLE);
  assign dial_position     = r_pos;
  assign hits              = r_hits;
  assign passes            = r_passes;
  assign instructions_done = r_done;
  assign o_state_dbg       = r_state;

  // chunk <= DIAL_SIZE, so one conditional subtract/add keeps pos in range.
  assign w_rem_x   = XW'(r_remaining);
  assign w_chunk   = (w_rem_x >= N_X) ? N_A : AW'(w_rem_x);
  assign w_pos_a   = AW'(r_pos);
  assign w_sum     = w_pos_a + w_chunk;
  assign w_rem_sub = COUNT_WIDTH'(w_rem_x - XW'(w_chunk));

  always_comb begin
    w_pass      = 1'b0;
    w_new_pos_a = w_pos_a;
    if (r_dir) begin
      w_pass      = (w_sum >= N_A);
      w_new_pos_a = w_pass ? (w_sum - N_A) : w_sum;
    end else if (w_pos_a != '0) begin
      w_pass      = (w_chunk >= w_pos_a);
      w_new_pos_a = (w_chunk <= w_pos_a) ? (w_pos_a - w_chunk) : (w_pos_a + N_A - w_chunk);
    end else begin
      w_pass      = (w_chunk == N_A);
      w_new_pos_a = w_pass ? '0 : (N_A - w_chunk);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pos_nxt    = r_pos;
    w_dir_nxt    = r_dir;
    w_rem_nxt    = r_remaining;
    w_hits_nxt   = r_hits;
    w_passes_nxt = r_passes;
    w_done_nxt   = r_done;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_dir_nxt   = w_head[COUNT_WIDTH];
          w_rem_nxt   = w_head[COUNT_WIDTH-1:0];
          w_state_nxt = (w_head[COUNT_WIDTH-1:0] == '0) ? S_FINISH : S_ROTATE;
        end
      end
      S_ROTATE: begin
        w_pos_nxt    = POS_WIDTH'(w_new_pos_a);
        w_passes_nxt = r_passes + 32'(w_pass);
        w_rem_nxt    = w_rem_sub;
        if (w_rem_sub == '0) w_state_nxt = S_FINISH;
      end
      S_FINISH: begin
        if (r_pos == '0) w_hits_nxt = r_hits + 32'd1;
        w_done_nxt  = r_done + 32'd1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pos       <= POS_WIDTH'(START_POS);
      r_dir       <= 1'b0;
      r_remaining <= '0;
      r_hits      <= '0;
      r_passes    <= '0;
      r_done      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pos       <= w_pos_nxt;
      r_dir       <= w_dir_nxt;
      r_remaining <= w_rem_nxt;
      r_hits      <= w_hits_nxt;
      r_passes    <= w_passes_nxt;
      r_done      <= w_done_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[FAW-1:0]] <= {instr.direction, instr.count};
  end

endmodule
